// File: rtl/controller_tc1_pkg.sv
// rtl/controller_tc1_pkg.sv - shared constants and types for the tc1 control port
package controller_tc1_pkg;

    localparam int DEFAULT_DATA_WIDTH = 25;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    localparam logic [2:0] ADDR_LEVEL  = 3'd0;
    localparam logic [2:0] ADDR_WIDTH  = 3'd1;
    localparam logic [2:0] ADDR_TRIG   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/controller_tc1_pulse_timer.sv
// rtl/controller_tc1_pulse_timer.sv - shared down-counter driving one-shot pulses on a bit mask
module controller_tc1_pulse_timer
    import controller_tc1_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  trig_i,
    input  logic [DATA_WIDTH-1:0] trig_bits_i,
    input  logic [CNT_WIDTH-1:0]  width_i,
    output logic [DATA_WIDTH-1:0] active_mask_o,
    output logic                  done_pulse_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    timer_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  launch;
    logic                  expire;

    assign launch = trig_i && (width_i != '0) && (trig_bits_i != '0);
    assign expire = (state_q == ST_RUN) && (count_q == CNT_ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        count_d      = count_q;
        done_pulse_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    mask_d  = trig_bits_i;
                    count_d = width_i;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                done_pulse_o = expire;
                if (launch) begin
                    // A trigger on the final cycle starts a fresh pulse with only the new bits.
                    mask_d  = expire ? trig_bits_i : (mask_q | trig_bits_i);
                    count_d = width_i;
                end else if (expire) begin
                    mask_d  = '0;
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = '0;
                count_d = '0;
            end
        endcase
    end

    assign active_mask_o = mask_q;
    assign count_o       = count_q;

endmodule

// File: rtl/controller_tc1_control.sv
// rtl/controller_tc1_control.sv - Avalon-MM output port for timer channel 1 with one-shot pulses
module controller_tc1_control
    import controller_tc1_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] level_q, level_d;
    logic [CNT_WIDTH-1:0]  width_q, width_d;
    logic                  done_q, done_d;
    logic [31:0]           readdata_q, readdata_d;

    logic                  wr_strobe;
    logic                  trig_strobe;
    logic [DATA_WIDTH-1:0] wdata_bits;
    logic [DATA_WIDTH-1:0] active_mask;
    logic                  done_pulse;
    logic [CNT_WIDTH-1:0]  timer_count;

    assign wr_strobe   = chipselect && !write_n;
    assign trig_strobe = wr_strobe && (address == ADDR_TRIG);
    assign wdata_bits  = writedata[DATA_WIDTH-1:0];

    controller_tc1_pulse_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_pulse_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .trig_i        (trig_strobe),
        .trig_bits_i   (wdata_bits),
        .width_i       (width_q),
        .active_mask_o (active_mask),
        .done_pulse_o  (done_pulse),
        .count_o       (timer_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q    <= '0;
            width_q    <= '0;
            done_q     <= 1'b0;
            readdata_q <= '0;
        end else begin
            level_q    <= level_d;
            width_q    <= width_d;
            done_q     <= done_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        level_d = level_q;
        width_d = width_q;
        done_d  = done_q;
        if (wr_strobe) begin
            case (address)
                ADDR_LEVEL:  level_d = wdata_bits;
                ADDR_WIDTH:  width_d = writedata[CNT_WIDTH-1:0];
                ADDR_STATUS: done_d  = 1'b0;
                ADDR_OUTSET: level_d = level_q | wdata_bits;
                ADDR_OUTCLR: level_d = level_q & ~wdata_bits;
                default:     ;
            endcase
        end
        // Expiry outranks a simultaneous status-write clear.
        if (done_pulse) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_LEVEL:  readdata_d = 32'(level_q);
            ADDR_WIDTH:  readdata_d = 32'(width_q);
            ADDR_TRIG:   readdata_d = 32'(active_mask);
            ADDR_STATUS: readdata_d = {31'd0, done_q};
            default:     readdata_d = '0;
        endcase
    end

    assign readdata = readdata_q;
    assign out_port = level_q | active_mask;
    assign irq      = done_q;

    logic unused_sink;
    assign unused_sink = &{1'b0, writedata, timer_count};

endmodule

// File: tb/tb_controller_tc1_control.sv
// tb/tb_controller_tc1_control.sv - self-checking bench for controller_tc1_control
module tb_controller_tc1_control;

    localparam int DW = 25;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          irq;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    controller_tc1_control #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    // Reference model: pulse tracked as an absolute end edge rather than a down-counter.
    logic [DW-1:0] m_level;
    int            m_width;
    logic [DW-1:0] m_mask;
    int            m_end;
    bit            m_done;
    logic [31:0]   m_rd;
    int            m_edge;

    task automatic model_reset();
        m_level = '0; m_width = 0; m_mask = '0; m_end = 0;
        m_done = 0; m_rd = '0; m_edge = 0;
    endtask

    task automatic model_edge(input logic [2:0] a, input bit cs, input bit wn, input logic [31:0] wd);
        bit            wr;
        bit            expire;
        logic [DW-1:0] bits;
        logic [DW-1:0] mask_n;
        m_edge = m_edge + 1;
        wr     = cs && !wn;
        bits   = wd[DW-1:0];
        expire = (m_mask != '0) && (m_edge == m_end);
        case (a)
            3'd0:    m_rd = 32'(m_level);
            3'd1:    m_rd = 32'(m_width);
            3'd2:    m_rd = 32'(m_mask);
            3'd3:    m_rd = {31'd0, m_done};
            default: m_rd = 32'd0;
        endcase
        mask_n = expire ? '0 : m_mask;
        if (wr) begin
            case (a)
                3'd0: m_level = bits;
                3'd1: m_width = int'(wd[CW-1:0]);
                3'd2: if (m_width != 0 && bits != '0) begin
                          mask_n = mask_n | bits;
                          m_end  = m_edge + m_width;
                      end
                3'd3: m_done = 0;
                3'd4: m_level = m_level | bits;
                3'd5: m_level = m_level & ~bits;
                default: ;
            endcase
        end
        if (expire) m_done = 1;
        m_mask = mask_n;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [2:0] a, input bit cs, input bit wn, input logic [31:0] wd);
        address = a; chipselect = cs; write_n = wn; writedata = wd;
        @(posedge clk);
        model_edge(a, cs, wn, wd);
        #1;
        check("model_out_port", 32'(out_port), 32'(m_level | m_mask));
        check("model_irq", {31'd0, irq}, {31'd0, m_done});
        check("model_readdata", readdata, m_rd);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        step(a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        step(a, 1'b1, 1'b1, 32'd0);
    endtask

    task automatic idle();
        step(3'd0, 1'b0, 1'b1, 32'd0);
    endtask

    typedef struct {
        logic [2:0]    addr;
        bit            is_wr;
        logic [31:0]   wd;
        logic [DW-1:0] exp_out;
        bit            exp_irq;
        logic [31:0]   exp_rd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{3'd0, 1'b1, 32'h0F0, 25'h0F0, 1'b0, 32'h0};
        tbl[1] = '{3'd4, 1'b1, 32'h001, 25'h0F1, 1'b0, 32'h0};
        tbl[2] = '{3'd5, 1'b1, 32'h030, 25'h0C1, 1'b0, 32'h0};
        tbl[3] = '{3'd0, 1'b0, 32'h0,   25'h0C1, 1'b0, 32'h0C1};
        tbl[4] = '{3'd1, 1'b1, 32'h4,   25'h0C1, 1'b0, 32'h0};
        tbl[5] = '{3'd1, 1'b0, 32'h0,   25'h0C1, 1'b0, 32'h4};
        tbl[6] = '{3'd0, 1'b1, 32'h0,   25'h000, 1'b0, 32'h0C1};

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_port", 32'(out_port), 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_readdata", readdata, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].addr, 1'b1, !tbl[i].is_wr, tbl[i].wd);
            check("tbl_out_port", 32'(out_port), 32'(tbl[i].exp_out));
            check("tbl_irq", {31'd0, irq}, {31'd0, tbl[i].exp_irq});
            check("tbl_readdata", readdata, tbl[i].exp_rd);
        end

        // One-shot of width 4 on bit 8
        wr(3'd2, 32'h100);
        check("pulse_high0", {31'd0, out_port[8]}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("pulse_high", {31'd0, out_port[8]}, 32'd1);
            check("pulse_irq_low", {31'd0, irq}, 32'd0);
        end
        idle();
        check("pulse_fall", {31'd0, out_port[8]}, 32'd0);
        check("pulse_irq_rise", {31'd0, irq}, 32'd1);
        rd(3'd3);
        check("status_read", readdata, 32'd1);
        wr(3'd3, 32'd0);
        check("status_clear", {31'd0, irq}, 32'd0);

        // Retrigger restarts the full width for all active bits
        wr(3'd1, 32'd6);
        wr(3'd2, 32'h1);
        idle();
        idle();
        wr(3'd2, 32'h2);
        check("retrig_out0", 32'(out_port), 32'h3);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("retrig_out", 32'(out_port), 32'h3);
            check("retrig_irq_low", {31'd0, irq}, 32'd0);
        end
        idle();
        check("retrig_fall", 32'(out_port), 32'h0);
        check("retrig_irq", {31'd0, irq}, 32'd1);

        // Trigger on the final count cycle
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd4);
        wr(3'd2, 32'h1);
        idle();
        idle();
        idle();
        check("lastcyc_pre_out", 32'(out_port), 32'h1);
        check("lastcyc_pre_irq", {31'd0, irq}, 32'd0);
        wr(3'd2, 32'h4);
        check("lastcyc_out", 32'(out_port), 32'h4);
        check("lastcyc_irq", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("lastcyc_hold", 32'(out_port), 32'h4);
        end
        idle();
        check("lastcyc_fall", 32'(out_port), 32'h0);

        // Zero width trigger is ignored
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd2, 32'hFF);
        check("w0_out", 32'(out_port), 32'h0);
        idle();
        check("w0_out_later", 32'(out_port), 32'h0);
        check("w0_irq", {31'd0, irq}, 32'd0);
        rd(3'd2);
        check("w0_mask", readdata, 32'd0);

        // Status write coincident with expiry: set wins
        wr(3'd1, 32'd3);
        wr(3'd2, 32'h1);
        idle();
        idle();
        wr(3'd3, 32'd0);
        check("collide_irq", {31'd0, irq}, 32'd1);
        check("collide_out", 32'(out_port), 32'h0);
        rd(3'd3);
        check("collide_status", readdata, 32'd1);

        // Width rewrite during RUN leaves current pulse length alone
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd4);
        wr(3'd2, 32'h10);
        wr(3'd1, 32'd10);
        check("wrew_out1", 32'(out_port), 32'h10);
        idle();
        idle();
        check("wrew_out3", 32'(out_port), 32'h10);
        idle();
        check("wrew_fall", 32'(out_port), 32'h0);
        check("wrew_irq", {31'd0, irq}, 32'd1);
        rd(3'd1);
        check("wrew_width", readdata, 32'd10);

        // Reset asserted mid-pulse
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd5);
        wr(3'd2, 32'h3);
        check("prereset_out", 32'(out_port), 32'h3);
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("midreset_out", 32'(out_port), 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        check("midreset_rd", readdata, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            check("postreset_rd", readdata, 32'd0);
        end

        // Randomised traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            logic [2:0]  ra;
            bit          rcs;
            bit          rwn;
            logic [31:0] rwd;
            ra  = 3'($urandom_range(0, 7));
            rcs = ($urandom_range(0, 7) != 0);
            rwn = ($urandom_range(0, 2) == 0);
            rwd = $urandom;
            if (ra == 3'd1) rwd = (rwd & 32'hFFFF_0000) | $urandom_range(0, 9);
            if (ra == 3'd2 && $urandom_range(0, 1) == 1) rwd = (rwd & 32'hFF00_0000) | (32'd1 << $urandom_range(0, 24));
            step(ra, rcs, rwn, rwd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
